button_bounce_gen: RTL and testbench
====================================

BUTTON_BOUNCE_GEN -- requirements
Module: button_bounce_gen

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 1000, length in clk cycles of the bounce window after each requested edge (>=1).
REQ-002 Parameter STEP_DIV, default 16, clk cycles between candidate toggles inside the bounce window (>=1).
REQ-003 Parameter SETTLE_CYCLES, default 2000, clk cycles sw_out is held stable after the bounce window before completion (>=1).
REQ-004 Parameter LFSR_SEED, default 16'hACE1, LFSR start value.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 btn_target  input  1  clean requested button level, synchronous to clk.
REQ-008 sw_out  output  1  emulated noisy contact level, suitable as input to the team's debouncer.
REQ-009 busy  output  1  high while an edge event is in progress (BOUNCE or SETTLE).
REQ-010 settled_tick  output  1  one-cycle pulse when an event completes.

Function
REQ-011 FSM states IDLE, BOUNCE, SETTLE; sw_out, busy and settled_tick are registered.
REQ-012 IDLE: on an edge where btn_target != sw_out, latch target, set sw_out <= target, load bounce counter BOUNCE_CYCLES-1 and step counter STEP_DIV-1, go to BOUNCE.
REQ-013 BOUNCE: each cycle decrement both counters; when step counter is 0 and bounce counter is nonzero, issue a toggle candidate and reload step counter STEP_DIV-1.
REQ-014 BOUNCE: when bounce counter is 0, set sw_out <= latched target, load settle counter SETTLE_CYCLES-1, go to SETTLE; end-of-window wins over a simultaneous toggle candidate.
REQ-015 SETTLE: hold sw_out; when settle counter is 0, pulse settled_tick for exactly one cycle and go to IDLE.
REQ-016 btn_target changes during BOUNCE/SETTLE are ignored; IDLE re-compares on its first cycle, so a pending difference starts a new event with no gap cycle beyond that IDLE cycle.
REQ-017 busy = 1 in BOUNCE and SETTLE, 0 in IDLE.
REQ-018 Counters sized ceil(log2(param+1)) bits; no wrap-around is permitted by construction.

Reset
REQ-019 Reset asserted: state IDLE, sw_out 0, busy 0, settled_tick 0, all counters 0, LFSR = LFSR_SEED (16'h0001 if seed is 0).
REQ-020 Reset mid-event abandons the event immediately with no settled_tick; after release, btn_target=1 starts a fresh event.

Configuration
REQ-021 Macro BUTTON_BOUNCE_GEN_LFSR_EN defined: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) advances every cycle including IDLE; a toggle candidate toggles sw_out only when LFSR bit 0 is 1.
REQ-022 Macro undefined: no LFSR logic; every toggle candidate toggles sw_out (deterministic square bounce).

Structure
REQ-023 Shared package btn_bounce_pkg holds the state encoding, default parameter constants and LFSR polynomial/tap constants.
REQ-024 Sub-module lfsr16 (clk, reset, seed, state output) is instantiated only under BUTTON_BOUNCE_GEN_LFSR_EN.

Verification (BOUNCE_CYCLES=8, STEP_DIV=2, SETTLE_CYCLES=4, macro off unless stated; E0 = edge sampling the change)
REQ-025 btn_target 0->1 -> sw_out 1 after E0, 0 after E2, 1 after E4, 0 after E6, 1 from E8 on; settled_tick high only after E12; busy high E0..E11, low after E12.
REQ-026 btn_target 1->0 from settled high -> mirror sequence of REQ-025 ending sw_out=0, one settled_tick.
REQ-027 btn_target pulses 1 for 3 cycles from IDLE -> full rise event completes, then immediately a fall event; exactly two settled_ticks.
REQ-028 Reset asserted at E5 of a rise event -> sw_out, busy 0 asynchronously, no settled_tick; release with btn_target=1 -> new event per REQ-025.
REQ-029 Macro on, seed 16'hACE1 -> sw_out toggle pattern matches the reference LFSR model cycle for cycle; final level equals target at E8.
REQ-030 Macro on, seed 0 -> LFSR starts at 16'h0001, never locks at 0 over 70000 cycles.

Source files
------------

// File: rtl/btn_bounce_pkg.sv
// Shared types and constants for the button bounce generator.
// The LFSR constants are used only when BUTTON_BOUNCE_GEN_LFSR_EN is defined.
package btn_bounce_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BOUNCE = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   localparam int unsigned DEF_BOUNCE_CYCLES = 1000;
   localparam int unsigned DEF_STEP_DIV      = 16;
   localparam int unsigned DEF_SETTLE_CYCLES = 2000;
   localparam logic [15:0] DEF_LFSR_SEED     = 16'hACE1;

   // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
   localparam int unsigned LFSR_W    = 16;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // One Galois step.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

   // An all-zero seed would lock the register, so it is replaced by 1.
   function automatic logic [15:0] lfsr_fix_seed(input logic [15:0] seed);
      return (seed == 16'h0000) ? 16'h0001 : seed;
   endfunction

endpackage

// File: rtl/button_bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR, advancing every clock.
module lfsr16
   import btn_bounce_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] state
);

   // Load the (zero-guarded) seed on reset, otherwise step every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= lfsr_fix_seed(seed);
      else       state <= lfsr_next(state);
   end

endmodule

// File: rtl/button_bounce_gen.sv
// Emulates a bouncing mechanical contact for exercising a debouncer.
// Each requested level change produces a bounce window of toggles followed
// by a stable settle period and a one-cycle completion tick.
// Define BUTTON_BOUNCE_GEN_LFSR_EN to gate the toggles with a pseudo-random
// LFSR bit; otherwise every toggle candidate toggles (square bounce).
module button_bounce_gen
   import btn_bounce_pkg::*;
#(
   parameter int unsigned BOUNCE_CYCLES = DEF_BOUNCE_CYCLES,
   parameter int unsigned STEP_DIV      = DEF_STEP_DIV,
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter logic [15:0] LFSR_SEED     = DEF_LFSR_SEED
)
(
   input  logic clk,
   input  logic reset,
   input  logic btn_target,
   output logic sw_out,
   output logic busy,
   output logic settled_tick
);

   localparam int unsigned BW = $clog2(BOUNCE_CYCLES + 1);
   localparam int unsigned DW = $clog2(STEP_DIV + 1);
   localparam int unsigned TW = $clog2(SETTLE_CYCLES + 1);

   state_t         state;
   logic           target_q;
   logic [BW-1:0]  bounce_cnt;
   logic [DW-1:0]  step_cnt;
   logic [TW-1:0]  settle_cnt;
   logic           toggle_en_c;

`ifdef BUTTON_BOUNCE_GEN_LFSR_EN
   logic [LFSR_W-1:0] lfsr_state;

   lfsr16 u_lfsr16 (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED),
      .state (lfsr_state)
   );

   assign toggle_en_c = lfsr_state[0];
`else
   assign toggle_en_c = 1'b1;
`endif

   // Event sequencer: IDLE -> BOUNCE -> SETTLE -> IDLE, all outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         sw_out       <= 1'b0;
         busy         <= 1'b0;
         settled_tick <= 1'b0;
         target_q     <= 1'b0;
         bounce_cnt   <= '0;
         step_cnt     <= '0;
         settle_cnt   <= '0;
      end else begin
         settled_tick <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (btn_target != sw_out) begin
                  target_q   <= btn_target;
                  sw_out     <= btn_target;
                  bounce_cnt <= BW'(BOUNCE_CYCLES - 1);
                  step_cnt   <= DW'(STEP_DIV - 1);
                  busy       <= 1'b1;
                  state      <= ST_BOUNCE;
               end
            end
            ST_BOUNCE: begin
               // End of window takes priority over a coincident toggle.
               if (bounce_cnt == '0) begin
                  sw_out     <= target_q;
                  settle_cnt <= TW'(SETTLE_CYCLES - 1);
                  state      <= ST_SETTLE;
               end else begin
                  bounce_cnt <= bounce_cnt - BW'(1);
                  if (step_cnt == '0) begin
                     step_cnt <= DW'(STEP_DIV - 1);
                     if (toggle_en_c) sw_out <= ~sw_out;
                  end else begin
                     step_cnt <= step_cnt - DW'(1);
                  end
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == '0) begin
                  settled_tick <= 1'b1;
                  busy         <= 1'b0;
                  state        <= ST_IDLE;
               end else begin
                  settle_cnt <= settle_cnt - TW'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_bounce_gen.sv
// Scoreboard bench for button_bounce_gen (BOUNCE_CYCLES=8, STEP_DIV=2,
// SETTLE_CYCLES=4). Stimulus pushes per-cycle expected {sw_out,busy,tick};
// a monitor pops one entry per clock and compares.
module tb_button_bounce_gen;

   localparam logic [15:0] SEED = 16'hACE1;
`ifdef BUTTON_BOUNCE_GEN_LFSR_EN
   localparam bit LFSR_ON = 1'b1;
`else
   localparam bit LFSR_ON = 1'b0;
`endif

   // Hand-derived rise-event trace, bit k = value sampled after edge Ek.
   localparam logic [12:0] RISE_SW  = 13'b1111100110011;
   localparam logic [12:0] BUSY_TBL = 13'b0111111111111;
   localparam logic [12:0] TICK_TBL = 13'b1000000000000;

   logic clk = 1'b0;
   logic reset;
   logic btn_target;
   logic sw_out;
   logic busy;
   logic settled_tick;

   always #5 clk = ~clk;

   button_bounce_gen #(
      .BOUNCE_CYCLES (8),
      .STEP_DIV      (2),
      .SETTLE_CYCLES (4),
      .LFSR_SEED     (SEED)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_target   (btn_target),
      .sw_out       (sw_out),
      .busy         (busy),
      .settled_tick (settled_tick)
   );

   typedef struct {
      logic [2:0] exp;
      int         k;
      string      tag;
   } item_t;

   item_t       sbq[$];
   int          checks = 0;
   int          failures = 0;
   int          ticks_seen = 0;
   int          ticks_exp = 0;
   logic        idle_lvl = 1'b0;
   bit          mon_en = 1'b0;
   logic [15:0] lfsr_m;

   function automatic logic [15:0] adv(input logic [15:0] s);
      logic [15:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   // Expected outputs after edge Ek of an event starting with LFSR value l0.
   function automatic logic [2:0] exp_at(input int k, input logic tgt, input logic [15:0] l0);
      logic [15:0] l;
      logic        lvl;
      logic [12:0] sw_tbl;
      logic [12:0] bz_tbl;
      logic [12:0] tk_tbl;
      sw_tbl = RISE_SW;
      bz_tbl = BUSY_TBL;
      tk_tbl = TICK_TBL;
      l   = l0;
      lvl = tgt;
      for (int j = 1; j <= 7; j++) begin
         l = adv(l);
         if ((j == 2 || j == 4 || j == 6) && j <= k && (LFSR_ON ? l[0] : 1'b1)) lvl = ~lvl;
      end
      if (k >= 8) lvl = tgt;
      if (!LFSR_ON) lvl = tgt ? sw_tbl[k] : ~sw_tbl[k];
      return {lvl, bz_tbl[k], tk_tbl[k]};
   endfunction

   function automatic logic [15:0] adv_n(input logic [15:0] s, input int n);
      logic [15:0] r;
      r = s;
      for (int i = 0; i < n; i++) r = adv(r);
      return r;
   endfunction

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: {sw,busy,tick} got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_event(input logic tgt, input logic [15:0] l0, input int upto, input string tag);
      for (int k = 0; k <= upto; k++) sbq.push_back('{exp_at(k, tgt, l0), k, tag});
      if (upto == 12) begin
         ticks_exp++;
         idle_lvl = tgt;
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL drain_%s: %0d entries left, required 0", tag, sbq.size());
         sbq.delete();
      end
   endtask

   // Reference LFSR, held at the seed during reset.
   always @(posedge clk or posedge reset) begin
      if (reset) lfsr_m <= (SEED == 16'h0000) ? 16'h0001 : SEED;
      else       lfsr_m <= adv(lfsr_m);
   end

   // Monitor: one comparison per clock, scoreboard entry or idle expectation.
   always @(posedge clk) begin
      item_t it;
      #1;
      if (mon_en) begin
         if (settled_tick) ticks_seen++;
         if (sbq.size() > 0) begin
            it = sbq.pop_front();
            check($sformatf("%s_E%0d", it.tag, it.k), {sw_out, busy, settled_tick}, it.exp);
         end else begin
            check("idle", {sw_out, busy, settled_tick}, {idle_lvl, 2'b00});
         end
      end
   end

   initial begin
      logic [15:0] l0;
      reset      = 1'b1;
      btn_target = 1'b0;
      #3;
      check("reset_init", {sw_out, busy, settled_tick}, 3'b000);
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;
      repeat (3) @(negedge clk);

      btn_target = 1'b1;
      push_event(1'b1, lfsr_m, 12, "rise");
      drain("rise");
      repeat (3) @(negedge clk);

      btn_target = 1'b0;
      push_event(1'b0, lfsr_m, 12, "fall");
      drain("fall");
      repeat (3) @(negedge clk);

      btn_target = 1'b1;
      l0 = lfsr_m;
      push_event(1'b1, l0, 12, "pulse_rise");
      push_event(1'b0, adv_n(l0, 13), 12, "pulse_fall");
      repeat (3) @(negedge clk);
      btn_target = 1'b0;
      drain("pulse");
      repeat (3) @(negedge clk);

      btn_target = 1'b1;
      push_event(1'b1, lfsr_m, 5, "abort_rise");
      repeat (6) @(posedge clk);
      #2;
      reset    = 1'b1;
      idle_lvl = 1'b0;
      #1;
      check("reset_async_sw",   {sw_out, 2'b00}, 3'b000);
      check("reset_async_busy", {1'b0, busy, 1'b0}, 3'b000);
      check("reset_async_tick", {2'b00, settled_tick}, 3'b000);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      push_event(1'b1, lfsr_m, 12, "post_reset");
      drain("post_reset");
      repeat (3) @(negedge clk);

      checks++;
      if (ticks_seen != 5 || ticks_seen != ticks_exp) begin
         failures++;
         $display("FAIL tick_count: got %0d expected 5", ticks_seen);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
